mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Memory-stage access controller for the pipelined ARM core. It sits between the EX/MEM pipeline register outputs and a data memory that may take several cycles to respond, using a req/ack handshake. It sequences each load or store as a handshake with that memory and freezes the pipeline until the access completes. It also inserts bubbles into writeback and reports faults: misaligned addresses and timeouts.

## Interface
- TIMEOUT, 255: max cycles in BUSY without DmAck before a timeout fault (1..255)
- CNT_W, 16: width of AccessCount

- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-low reset (reset==0 sampled at posedge clears state)
- MemWriteM  input  1  store in M stage
- MemtoRegM  input  1  load in M stage
- ALUResultM  input  32  byte address
- WriteDataM  input  32  store data
- DmReq  output  1  memory request, registered
- DmWe  output  1  1=write, registered
- DmAddr  output  32  registered address
- DmWData  output  32  registered write data
- DmAck  input  1  memory completion, single-cycle pulse
- DmRData  input  32  read data, valid when DmAck=1
- ReadDataM  output  32  registered load data to MEM/WB register
- StallPipe  output  1  combinational; holds F/D/E/M pipeline registers
- BubbleW  output  1  combinational; forces RegWrite=0 into MEM/WB register; equals StallPipe
- MemFault  output  1  sticky fault flag
- AccessCount  output  CNT_W  completed (acked) accesses, wraps

## Operation
- States: IDLE, BUSY, DONE.
- Access present: acc = MemWriteM | MemtoRegM. Both high means a write; MemtoRegM is ignored.
- IDLE, acc=1, ALUResultM[1:0]==0:
  - StallPipe=1.
  - Next edge: DmReq=1, DmWe=MemWriteM, DmAddr=ALUResultM, DmWData=WriteDataM, timer=0, go to BUSY.
- IDLE, acc=1, ALUResultM[1:0]!=0 (misaligned):
  - StallPipe=1.
  - Next edge: no request issued, MemFault=1, ReadDataM=0, go to DONE.
- IDLE, acc=0: StallPipe=0, stay in IDLE.
- BUSY:
  - DmReq, DmWe, DmAddr and DmWData are held stable.
  - DmAck=1: StallPipe=1. Next edge: DmReq=0; ReadDataM=DmRData on a load, unchanged on a store; AccessCount+1; go to DONE.
  - DmAck=0 and timer==TIMEOUT-1: StallPipe=1. Next edge: DmReq=0, MemFault=1, ReadDataM=0, go to DONE.
  - Otherwise: StallPipe=1, timer+1.
  - DmAck and timeout in the same cycle: DmAck wins, no fault.
- DONE:
  - StallPipe=0, so the pipeline advances at this edge. acc is ignored (it still shows the finished instruction).
  - Next edge: go to IDLE.
- DmAck sampled in IDLE or DONE is ignored.
- MemFault clears only on reset. Later accesses proceed normally.
- AccessCount wraps from 2^CNT_W-1 to 0. Faulted accesses are not counted.

## Timing
- Reset values: state=IDLE, DmReq=0, DmWe=0, DmAddr=0, DmWData=0, ReadDataM=0, MemFault=0, AccessCount=0, timer=0.
- While reset==0, StallPipe=BubbleW=0 (combinational override).
- Reset asserted mid-access: DmReq drops at that edge and the outstanding access is abandoned.
- Latency, with access entering M at cycle 0 (IDLE):
  - DmReq is high from cycle 1.
  - Ack in cycle k≥1 puts the block in DONE at k+1 with ReadDataM valid.
  - The pipeline advances at the end of cycle k+1; the minimum M-stage residency is 3 cycles.
- Back-to-back accesses: the next instruction reaches M at the end of DONE and is seen in IDLE the following cycle. There are no dead cycles beyond DONE.
- Timeout: with no ack, DONE occurs at cycle TIMEOUT+1.

## Test plan
- Load, ALUResultM=0x100, DmAck in cycle 1 with DmRData=0xCAFEF00D -> DmReq high cycle 1 only; StallPipe=1 cycles 0-1, 0 in cycle 2; ReadDataM=0xCAFEF00D in cycle 2; AccessCount=1.
- Store, ALUResultM=0x204, WriteDataM=0x12345678, ack delayed to cycle 5 -> DmWe=1; DmAddr/DmWData stable cycles 1-5; StallPipe=1 cycles 0-5; ReadDataM unchanged.
- Load, ALUResultM=0x102 -> DmReq never asserted; MemFault=1 from cycle 1; DONE in cycle 1; ReadDataM=0.
- TIMEOUT=4, no ack -> DmReq high cycles 1-4, low at cycle 5; DONE in cycle 5; MemFault=1. Same setup with ack in cycle 4 -> no fault.
- Reset low during BUSY (cycle 2) -> at that edge DmReq=0 and state=IDLE; StallPipe=0 while reset low; a spurious DmAck at cycle 4 is ignored; AccessCount stays 0.
- Two consecutive loads, each acked in its first BUSY cycle -> DmReq pulses at cycles 1 and 4; AccessCount=2; AccessCount preloaded to 0xFFFF wraps to 0x0001.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: sequences one load/store per M-stage instruction
// over a req/ack data-memory port, stalls the pipeline meanwhile and flags faults.
module mem_access_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemWriteM,
    input  logic             MemtoRegM,
    input  logic [31:0]      ALUResultM,
    input  logic [31:0]      WriteDataM,
    output logic             DmReq,
    output logic             DmWe,
    output logic [31:0]      DmAddr,
    output logic [31:0]      DmWData,
    input  logic             DmAck,
    input  logic [31:0]      DmRData,
    output logic [31:0]      ReadDataM,
    output logic             StallPipe,
    output logic             BubbleW,
    output logic             MemFault,
    output logic [CNT_W-1:0] AccessCount
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t      state_r;
    state_t      state_s;
    logic [7:0]  timer_r;
    logic        acc_s;
    logic        aligned_s;
    logic        timeout_s;
    logic        stall_s;

    assign acc_s     = MemWriteM | MemtoRegM;
    assign aligned_s = (ALUResultM[1:0] == 2'b00);
    assign timeout_s = (timer_r == TIMER_LAST);

    // Next-state and raw stall decode.
    always_comb begin
        state_s = state_r;
        stall_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (acc_s) begin
                    stall_s = 1'b1;
                    state_s = aligned_s ? BUSY : DONE;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                stall_s = 1'b1;
                if (DmAck || timeout_s) begin
                    state_s = DONE;
                end else begin
                    state_s = BUSY;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Stall is forced low while reset is held so the pipeline flushes freely.
    always_comb begin
        if (reset) begin
            StallPipe = stall_s;
        end else begin
            StallPipe = 1'b0;
        end
        BubbleW = StallPipe;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Memory port, load data, fault flag, timer and completion counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            DmReq       <= 1'b0;
            DmWe        <= 1'b0;
            DmAddr      <= 32'd0;
            DmWData     <= 32'd0;
            ReadDataM   <= 32'd0;
            MemFault    <= 1'b0;
            AccessCount <= {CNT_W{1'b0}};
            timer_r     <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (acc_s && aligned_s) begin
                        DmReq   <= 1'b1;
                        DmWe    <= MemWriteM;
                        DmAddr  <= ALUResultM;
                        DmWData <= WriteDataM;
                        timer_r <= 8'd0;
                    end else if (acc_s) begin
                        MemFault  <= 1'b1;
                        ReadDataM <= 32'd0;
                    end
                end
                BUSY: begin
                    // An ack in the final timer cycle still completes the access.
                    if (DmAck) begin
                        DmReq       <= 1'b0;
                        AccessCount <= AccessCount + CNT_W'(1);
                        if (!DmWe) begin
                            ReadDataM <= DmRData;
                        end
                    end else if (timeout_s) begin
                        DmReq     <= 1'b0;
                        MemFault  <= 1'b1;
                        ReadDataM <= 32'd0;
                    end else begin
                        timer_r <= timer_r + 8'd1;
                    end
                end
                DONE: begin
                    timer_r <= 8'd0;
                end
                default: begin
                    DmReq <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: stimulus pushes the expected outcome of each
// access; a monitor observes each completion and checks latency, port activity and results.
module tb_mem_access_ctrl;

    localparam int TO  = 4;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          MemWriteM, MemtoRegM;
    logic [31:0]   ALUResultM, WriteDataM;
    logic          DmReq, DmWe;
    logic [31:0]   DmAddr, DmWData;
    logic          DmAck;
    logic [31:0]   DmRData, ReadDataM;
    logic          StallPipe, BubbleW, MemFault;
    logic [CW-1:0] AccessCount;

    mem_access_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .DmReq(DmReq), .DmWe(DmWe), .DmAddr(DmAddr), .DmWData(DmWData),
        .DmAck(DmAck), .DmRData(DmRData), .ReadDataM(ReadDataM),
        .StallPipe(StallPipe), .BubbleW(BubbleW), .MemFault(MemFault),
        .AccessCount(AccessCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   rd;
        logic          fault;
        logic [CW-1:0] cnt;
        int            dur;
        int            reqn;
        logic          issued;
        logic          we;
        logic [31:0]   addr;
        logic [31:0]   wdata;
    } exp_t;

    exp_t          q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [31:0]   m_rd;
    logic          m_fault;
    logic [CW-1:0] m_cnt;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Monitor: tracks each stalled access and scores it on the DONE cycle.
    bit          active = 1'b0;
    int          cyc, reqn;
    bit          stable;
    logic        c_we;
    logic [31:0] c_addr, c_wdata;

    always @(negedge clk) begin
        if (!reset) begin
            active = 1'b0;
        end else begin
            if (StallPipe && !active) begin
                active = 1'b1; cyc = 0; reqn = 0; stable = 1'b1;
            end else if (active) begin
                cyc++;
            end
            if (active) begin
                chk("bubble_eq_stall", {31'd0, BubbleW}, {31'd0, StallPipe});
                if (DmReq) begin
                    reqn++;
                    if (reqn == 1) begin
                        c_we = DmWe; c_addr = DmAddr; c_wdata = DmWData;
                    end else if (DmWe !== c_we || DmAddr !== c_addr || DmWData !== c_wdata) begin
                        stable = 1'b0;
                    end
                end
                if (!StallPipe) begin
                    active = 1'b0;
                    if (q.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("done_cycle", cyc, e.dur);
                        chk("req_cycles", reqn, e.reqn);
                        chk("req_stable", {31'd0, stable}, 32'd1);
                        chk("read_data", ReadDataM, e.rd);
                        chk("mem_fault", {31'd0, MemFault}, {31'd0, e.fault});
                        chk("access_count", {28'd0, AccessCount}, {28'd0, e.cnt});
                        if (e.issued) begin
                            chk("dm_we", {31'd0, c_we}, {31'd0, e.we});
                            chk("dm_addr", c_addr, e.addr);
                            chk("dm_wdata", c_wdata, e.wdata);
                        end
                    end
                end
            end
        end
    end

    // One access starting now (cycle 0, state IDLE); ack = 0 means never acked.
    task automatic do_access(input logic wr, input logic ld, input logic [31:0] addr,
                             input logic [31:0] wd, input int ack, input logic [31:0] rdat);
        exp_t e;
        int   done;
        bit   misal;
        misal = (addr[1:0] != 2'b00);
        if (misal) begin
            done = 1; e.reqn = 0; m_fault = 1'b1; m_rd = 32'd0;
        end else if (ack > 0) begin
            done = ack + 1; e.reqn = ack; m_cnt = m_cnt + 1'b1;
            if (!wr) m_rd = rdat;
        end else begin
            done = TO + 1; e.reqn = TO; m_fault = 1'b1; m_rd = 32'd0;
        end
        e.rd = m_rd; e.fault = m_fault; e.cnt = m_cnt; e.dur = done;
        e.issued = !misal; e.we = wr; e.addr = addr; e.wdata = wd;
        q.push_back(e);
        MemWriteM = wr; MemtoRegM = ld; ALUResultM = addr; WriteDataM = wd;
        for (int c = 1; c <= done; c++) begin
            @(posedge clk); #1;
            DmAck   = (c == ack);
            DmRData = (c == ack) ? rdat : 32'hDEAD_BEEF;
        end
        @(posedge clk); #1;
        DmAck = 1'b0;
    endtask

    task automatic idle(input int n, input bit spur);
        MemWriteM = 1'b0; MemtoRegM = 1'b0;
        for (int i = 0; i < n; i++) begin
            DmAck = spur && (i == 0);
            @(posedge clk); #1;
        end
        DmAck = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; MemWriteM = 1'b1; MemtoRegM = 1'b0;
        ALUResultM = 32'h0000_0100; WriteDataM = 32'd0; DmAck = 1'b0; DmRData = 32'd0;
        m_rd = 32'd0; m_fault = 1'b0; m_cnt = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'd0, StallPipe}, 32'd0);
        chk("rst_bubble", {31'd0, BubbleW}, 32'd0);
        chk("rst_req", {31'd0, DmReq}, 32'd0);
        chk("rst_we", {31'd0, DmWe}, 32'd0);
        chk("rst_addr", DmAddr, 32'd0);
        chk("rst_wdata", DmWData, 32'd0);
        chk("rst_rdata", ReadDataM, 32'd0);
        chk("rst_fault", {31'd0, MemFault}, 32'd0);
        chk("rst_count", {28'd0, AccessCount}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1; MemWriteM = 1'b0;
        idle(2, 1'b1);

        do_access(1'b0, 1'b1, 32'h0000_0100, 32'd0, 1, 32'hCAFE_F00D);
        do_access(1'b1, 1'b0, 32'h0000_0204, 32'h1234_5678, 4, 32'h5555_AAAA);
        do_access(1'b0, 1'b1, 32'h0000_0102, 32'd0, 0, 32'd0);
        idle(1, 1'b0);
        do_access(1'b0, 1'b1, 32'h0000_0108, 32'd0, 0, 32'd0);
        idle(1, 1'b1);

        // Reset in the second BUSY cycle abandons the access; a later ack is ignored.
        MemtoRegM = 1'b1; ALUResultM = 32'h0000_0300;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0; MemtoRegM = 1'b0;
        @(negedge clk);
        chk("midrst_stall", {31'd0, StallPipe}, 32'd0);
        chk("midrst_req_before_edge", {31'd0, DmReq}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        chk("midrst_req_after_edge", {31'd0, DmReq}, 32'd0);
        @(posedge clk); #1;
        DmAck = 1'b1; DmRData = 32'h7777_7777;
        @(posedge clk); #1;
        DmAck = 1'b0;
        chk("midrst_count", {28'd0, AccessCount}, 32'd0);
        chk("midrst_rdata", ReadDataM, 32'd0);
        chk("midrst_fault", {31'd0, MemFault}, 32'd0);
        chk("midrst_req_idle", {31'd0, DmReq}, 32'd0);
        m_rd = 32'd0; m_fault = 1'b0; m_cnt = '0;

        do_access(1'b0, 1'b1, 32'h0000_0500, 32'd0, 1, 32'hAAAA_0001);
        do_access(1'b0, 1'b1, 32'h0000_0504, 32'd0, 1, 32'hAAAA_0002);
        do_access(1'b1, 1'b1, 32'h0000_0208, 32'h0BAD_CAFE, 1, 32'h9999_9999);
        for (int i = 0; i < 14; i++) begin
            do_access(1'b0, 1'b1, 32'h0000_0400 + 32'(i * 4), 32'd0, 1 + (i % 3),
                      32'h0000_1000 + 32'(i));
        end
        idle(3, 1'b0);
        chk("final_count_wrapped", {28'd0, AccessCount}, 32'd1);
        chk("scoreboard_empty", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
